// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: the producer side of the IF/ID pipeline register.
//
// It owns the PC and issues instruction-memory reads over a req/ready handshake.
// It presents each fetched instruction to IF/ID with its PC and PC+1.
//   - Variable memory latency: a read cannot be withdrawn once it is issued. The
//     address is held steady until imem_ready is seen.
//   - Downstream stall: one completed instruction can be parked in a hold buffer.
//     It is presented once stall drops.
//   - Redirect: flushes IF/ID, discards any buffered or in-flight instruction and
//     resumes fetching at redirect_pc. Redirect wins over stall everywhere.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   stall                   downstream cannot accept an instruction this cycle
//   redirect_valid/_pc      one-cycle redirect request and its target
//   imem_req/addr           read request and address (to instruction memory)
//   imem_ready/rdata        read completion strobe and data (from instruction memory)
//   PC_out_IF               PC of the presented instruction
//   PC_plus1_out_IF         PC_out_IF + 1
//   Instruction_out_IF      presented instruction (NOP_INSTR when not valid)
//   Valid_out_IF            presented instruction is real
//   flush_out_IF            IF/ID flush, asserted for the redirect cycle
module instr_fetch_stage #(
  parameter int unsigned                   PC_WIDTH    = 16,
  parameter int unsigned                   INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]           RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]        NOP_INSTR   = '1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    PC_out_IF,
  output logic [PC_WIDTH-1:0]    PC_plus1_out_IF,
  output logic [INSTR_WIDTH-1:0] Instruction_out_IF,
  output logic                   Valid_out_IF,
  output logic                   flush_out_IF
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    hold_pc_q, hold_pc_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [PC_WIDTH-1:0]    drain_addr_q, drain_addr_d;

  logic                   pres_valid;
  logic [PC_WIDTH-1:0]    pres_pc;
  logic [INSTR_WIDTH-1:0] pres_instr;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    drain_addr_d = drain_addr_q;
    imem_req     = 1'b0;
    imem_addr    = pc_q;
    pres_valid   = 1'b0;
    pres_pc      = '0;
    pres_instr   = NOP_INSTR;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (redirect_valid) pc_d = redirect_pc;
      end

      StFetch: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          pc_d = redirect_pc;
          // The pending read cannot be withdrawn: finish it at the old address and drop it.
          if (!imem_ready) begin
            drain_addr_d = pc_q;
            state_d      = StDrain;
          end
        end else if (imem_ready) begin
          pc_d = pc_q + PC_WIDTH'(1);
          if (!stall) begin
            pres_valid = 1'b1;
            pres_pc    = pc_q;
            pres_instr = imem_rdata;
          end else begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem_rdata;
            state_d      = StHold;
          end
        end
      end

      StHold: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = StFetch;
        end else if (!stall) begin
          pres_valid = 1'b1;
          pres_pc    = hold_pc_q;
          pres_instr = hold_instr_q;
          state_d    = StFetch;
        end
      end

      StDrain: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
        if (redirect_valid) pc_d = redirect_pc;
        if (imem_ready) state_d = StFetch;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      hold_pc_q    <= '0;
      hold_instr_q <= NOP_INSTR;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign Valid_out_IF       = pres_valid;
  assign PC_out_IF          = pres_pc;
  assign PC_plus1_out_IF    = pres_valid ? pres_pc + PC_WIDTH'(1) : '0;
  assign Instruction_out_IF = pres_instr;
  assign flush_out_IF       = redirect_valid & reset_n;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage. Memory contents are a fixed function of the
// address. The reference model holds the architectural stream: presented PCs run consecutively
// and restart at the target after each redirect, or at RESET_PC after reset. Each issued cycle
// of stimulus is queued with its expectations, and a negedge monitor pops it and compares.
module tb_instr_fetch_stage;

  localparam logic [15:0] ResetPc = 16'h0000;
  localparam logic [15:0] Nop     = 16'hFFFF;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_rdata;
  logic [15:0] pc_out, pc_plus1_out, instr_out;
  logic        valid_out, flush_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [15:0] tgt;
    int          ev;     // 0: don't care, 1: Valid must be 0, 2: Valid must be 1
    logic        noreq;  // imem_req must be 0
  } stim_t;

  stim_t stim_q[$];

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], ~a[15:8]} ^ 16'h5A3C;
  endfunction

  assign imem_rdata = mem_fn(imem_addr);

  always #5 clock = ~clock;

  instr_fetch_stage #(
    .PC_WIDTH   (16),
    .INSTR_WIDTH(16),
    .RESET_PC   (ResetPc),
    .NOP_INSTR  (Nop)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rdata        (imem_rdata),
    .PC_out_IF         (pc_out),
    .PC_plus1_out_IF   (pc_plus1_out),
    .Instruction_out_IF(instr_out),
    .Valid_out_IF      (valid_out),
    .flush_out_IF      (flush_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  logic [15:0] exp_pc = ResetPc;
  logic        prev_pending = 1'b0;
  logic [15:0] prev_addr = '0;

  always @(negedge clock) begin
    if (stim_q.size() > 0) begin
      stim_t r;
      r = stim_q.pop_front();
      if (r.rst) begin
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_instr", {16'd0, instr_out}, {16'd0, Nop});
        chk("rst_pc", {16'd0, pc_out}, 32'd0);
        chk("rst_pc1", {16'd0, pc_plus1_out}, 32'd0);
        chk("rst_flush", {31'd0, flush_out}, 32'd0);
        exp_pc       = ResetPc;
        prev_pending = 1'b0;
      end else begin
        if (prev_pending) begin
          chk("req_held", {31'd0, imem_req}, 32'd1);
          chk("addr_stable", {16'd0, imem_addr}, {16'd0, prev_addr});
        end
        chk("flush", {31'd0, flush_out}, {31'd0, r.redir});
        chk("valid_under_stall", {31'd0, valid_out & r.stall}, 32'd0);
        if (r.redir) begin
          chk("valid_on_redirect", {31'd0, valid_out}, 32'd0);
          exp_pc = r.tgt;
        end else if (valid_out) begin
          chk("pc", {16'd0, pc_out}, {16'd0, exp_pc});
          chk("pc_plus1", {16'd0, pc_plus1_out}, {16'd0, 16'(exp_pc + 16'd1)});
          chk("instr", {16'd0, instr_out}, {16'd0, mem_fn(exp_pc)});
          exp_pc = exp_pc + 16'd1;
        end
        if (!valid_out) begin
          chk("idle_instr", {16'd0, instr_out}, {16'd0, Nop});
          chk("idle_pc", {16'd0, pc_out}, 32'd0);
          chk("idle_pc1", {16'd0, pc_plus1_out}, 32'd0);
        end
        if (r.ev != 0) chk("valid_expect", {31'd0, valid_out}, (r.ev == 2) ? 32'd1 : 32'd0);
        if (r.noreq) chk("no_req", {31'd0, imem_req}, 32'd0);
        prev_pending = imem_req & ~imem_ready;
        prev_addr    = imem_addr;
      end
    end
  end

  task automatic cyc(input logic rst, input logic st, input logic rv, input logic [15:0] tg,
                     input logic rdy, input int ev, input logic nr);
    stim_t r;
    @(posedge clock);
    #1;
    reset_n        = ~rst;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = tg;
    imem_ready     = rdy;
    r.rst = rst; r.stall = st; r.redir = rv; r.tgt = tg; r.ev = ev; r.noreq = nr;
    stim_q.push_back(r);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    // Reset, then zero-wait streaming: IDLE for one cycle, then PC 0,1,2,3.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 16'h0, 1, 0, 1);
    cyc(0, 0, 0, 16'h0, 1, 1, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 16'h0, 1, 2, 0);

    // Ready only every third cycle: one Valid per completion.
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 16'h0, (i % 3 == 2), (i % 3 == 2) ? 2 : 1, 0);

    // Stall for 4 cycles as a read completes; held instruction comes out afterwards.
    cyc(0, 1, 0, 16'h0, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 16'h0, 1, 1, 1);
    cyc(0, 0, 0, 16'h0, 1, 2, 1);
    cyc(0, 0, 0, 16'h0, 1, 2, 0);

    // Redirect while a read is pending: drain, discard, resume at 0x0040.
    cyc(0, 0, 0, 16'h0, 0, 1, 0);
    cyc(0, 0, 1, 16'h0040, 0, 1, 0);
    cyc(0, 0, 0, 16'h0, 0, 1, 0);
    cyc(0, 0, 0, 16'h0, 1, 1, 0);
    cyc(0, 0, 0, 16'h0, 1, 2, 0);

    // PC wrap: redirect to 0xFFFF, then PC_plus1 = 0 and the next fetch is 0.
    cyc(0, 0, 1, 16'hFFFF, 1, 1, 0);
    cyc(0, 0, 0, 16'h0, 1, 2, 0);
    cyc(0, 0, 0, 16'h0, 1, 2, 0);

    // Reset in the middle of DRAIN, then stall+redirect together on release.
    cyc(0, 0, 1, 16'h0100, 0, 1, 0);
    cyc(1, 0, 0, 16'h0, 0, 0, 1);
    cyc(1, 0, 0, 16'h0, 0, 0, 1);
    cyc(0, 1, 1, 16'h1234, 1, 1, 1);
    cyc(0, 0, 0, 16'h0, 1, 2, 0);
    cyc(0, 0, 0, 16'h0, 1, 2, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        st, rv, rdy;
      logic [15:0] tg;
      st  = ($urandom % 10) < 3;
      rv  = ($urandom % 12) == 0;
      rdy = ($urandom % 10) < 6;
      tg  = ($urandom % 4 == 0) ? 16'(16'hFFFD + 16'($urandom % 3)) : 16'($urandom);
      cyc(0, st, rv, tg, rdy, 0, 0);
    end

    // Settle with clean traffic; streaming must resume at one instruction per cycle.
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 16'h0, 1, 2, 0);

    @(negedge clock);
    #1;
    chk("queue_drained", 32'(stim_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
